// File: rtl/ifmap_row_tagger_pkg.sv
// Shared widths, tag bit positions and FSM encoding for the IFmap row tagger.
package ifmap_row_tagger_pkg;

  localparam int DATA_W     = 16;
  localparam int TAG_W      = DATA_W + 2;
  localparam int ROW_LEN_W  = 8;
  localparam int ROWS_W     = 8;
  localparam int SKID_DEPTH = 2;
  localparam int SOR_BIT    = 17;
  localparam int EOR_BIT    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] make_tag(input logic sor, input logic eor,
                                                input logic [DATA_W-1:0] data);
    logic [TAG_W-1:0] word;
    word = {TAG_W{1'b0}};
    word[DATA_W-1:0] = data;
    word[SOR_BIT] = sor;
    word[EOR_BIT] = eor;
    return word;
  endfunction

endpackage

// File: rtl/ifmap_row_tagger_fifo.sv
// Two-entry skid FIFO holding tagged words between the upstream accept and the IF buffer write.
module tag_skid_fifo #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && (count_r != 2'd2);
  assign pop_ok_s  = pop && (count_r != 2'd0);

  // storage, pointers and occupancy; clr discards all contents
  always_ff @(posedge clk) begin
    if (!clr) begin
      mem_r[0] <= {WIDTH{1'b0}};
      mem_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = (count_r != 2'd0) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign count = count_r;

endmodule

// File: rtl/ifmap_row_tagger.sv
// Counts upstream activations into programmed rows and emits {sor, eor, data} words to the IF buffer.
module ifmap_row_tagger
  import ifmap_row_tagger_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_LEN_W-1:0] row_len,
  input  logic [ROWS_W-1:0]    num_rows,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  input  logic                 IF_full,
  output logic                 IF_wen,
  output logic [TAG_W-1:0]     IF_din,
  output logic                 busy,
  output logic                 done
);

  state_t               state_r;
  state_t               state_n;
  logic                 done_r;
  logic                 done_n;
  logic                 load_s;
  logic [ROW_LEN_W-1:0] row_len_r;
  logic [ROWS_W-1:0]    num_rows_r;
  logic [ROW_LEN_W-1:0] col_r;
  logic [ROWS_W-1:0]    row_r;
  logic [1:0]           fifo_count_s;
  logic [TAG_W-1:0]     fifo_head_s;
  logic                 accept_s;
  logic                 sor_s;
  logic                 eor_s;
  logic                 last_s;
  logic                 pop_s;

  assign in_ready = (state_r == ST_STREAM) && (fifo_count_s != 2'd2);
  assign accept_s = in_valid && in_ready;
  assign sor_s    = (col_r == {ROW_LEN_W{1'b0}});
  assign eor_s    = (col_r == (row_len_r - {{(ROW_LEN_W-1){1'b0}}, 1'b1}));
  assign last_s   = accept_s && eor_s && (row_r == (num_rows_r - {{(ROWS_W-1){1'b0}}, 1'b1}));
  assign pop_s    = (fifo_count_s != 2'd0) && !IF_full;

  assign IF_wen = pop_s;
  assign IF_din = fifo_head_s;
  assign busy   = (state_r != ST_IDLE);
  assign done   = done_r;

  tag_skid_fifo #(.WIDTH(TAG_W)) u_fifo (
    .clk   (clk),
    .clr   (rst),
    .push  (accept_s),
    .pop   (pop_s),
    .din   (make_tag(sor_s, eor_s, in_data)),
    .head  (fifo_head_s),
    .count (fifo_count_s)
  );

  // next-state and done decision
  always_comb begin
    state_n = state_r;
    done_n  = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if ((row_len != {ROW_LEN_W{1'b0}}) && (num_rows != {ROWS_W{1'b0}})) begin
            state_n = ST_STREAM;
            load_s  = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_s) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        // the frame ends on the edge that pops the final buffered word
        if ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s)) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state and done pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      done_r  <= done_n;
    end
  end

  // frame configuration and column/row position counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_len_r  <= {ROW_LEN_W{1'b0}};
      num_rows_r <= {ROWS_W{1'b0}};
      col_r      <= {ROW_LEN_W{1'b0}};
      row_r      <= {ROWS_W{1'b0}};
    end else if (load_s) begin
      row_len_r  <= row_len;
      num_rows_r <= num_rows;
      col_r      <= {ROW_LEN_W{1'b0}};
      row_r      <= {ROWS_W{1'b0}};
    end else if (accept_s) begin
      if (eor_s) begin
        col_r <= {ROW_LEN_W{1'b0}};
        row_r <= row_r + {{(ROWS_W-1){1'b0}}, 1'b1};
      end else begin
        col_r <= col_r + {{(ROW_LEN_W-1){1'b0}}, 1'b1};
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

endmodule

// File: tb/tb_ifmap_row_tagger.sv
// Self-checking bench: frames are scored against a queue of expected tagged words built from row/column arithmetic.
module tb_ifmap_row_tagger;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  row_len;
  logic [7:0]  num_rows;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        IF_full;
  logic        IF_wen;
  logic [17:0] IF_din;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  logic [15:0] src_q[$];
  logic [17:0] wr_log[$];

  ifmap_row_tagger dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .IF_full(IF_full),
    .IF_wen(IF_wen), .IF_din(IF_din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Runs one frame: inputs change on negedge, outputs are sampled 1 time unit later.
  task automatic run_frame(input int rl, input int nr, input int full_mode, input bit hold_valid,
                           input int restart_cyc, output int first_acc, output int first_wr,
                           output int last_wr, output int stalls);
    logic [17:0] exp_q[$];
    int total, si, wi, cyc;
    bit fin, exp_ready, exp_wen, sor_b, eor_b;
    logic [17:0] exp_din;
    total = rl * nr;
    for (int k = 0; k < total; k++) begin
      sor_b = ((k % rl) == 0);
      eor_b = ((k % rl) == rl - 1);
      exp_q.push_back({sor_b, eor_b, src_q[k]});
    end
    wr_log.delete();
    first_acc = -1; first_wr = -1; last_wr = -1; stalls = 0;
    @(negedge clk);
    start = 1'b1; row_len = rl[7:0]; num_rows = nr[7:0]; in_valid = 1'b0; IF_full = 1'b0;
    @(negedge clk);
    start = 1'b0;
    si = 0; wi = 0; fin = 1'b0;
    for (cyc = 0; cyc < 2000 && !fin; cyc++) begin
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        row_len = 8'(rl + 2);
        num_rows = 8'(nr + 1);
      end
      in_valid = (si < total) && (hold_valid || ($urandom_range(0, 99) < 70));
      in_data = (si < total) ? src_q[si] : 16'($urandom);
      IF_full = (full_mode < 0) ? ((cyc >= 2) && (cyc <= 6)) : ($urandom_range(0, 99) < full_mode);
      #1;
      exp_ready = (si < total) && ((si - wi) < 2);
      exp_wen = ((si - wi) > 0) && !IF_full;
      tests++;
      if (in_ready !== exp_ready) begin
        fails++; $display("FAIL in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ready);
      end
      tests++;
      if (IF_wen !== exp_wen) begin
        fails++; $display("FAIL IF_wen cyc %0d: got %b expected %b", cyc, IF_wen, exp_wen);
      end
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL busy/done cyc %0d: got %b/%b expected 1/0", cyc, busy, done);
      end
      if (IF_wen === 1'b1) begin
        tests++;
        if (wi >= total) begin
          fails++; $display("FAIL extra_write cyc %0d: got %h expected no write", cyc, IF_din);
        end else if (IF_din !== exp_q[wi]) begin
          fails++; $display("FAIL IF_din word %0d: got %h expected %h", wi, IF_din, exp_q[wi]);
        end
        wr_log.push_back(IF_din);
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        wi++;
        if (wi >= total) fin = 1'b1;
      end else begin
        exp_din = (si > wi) ? exp_q[wi] : 18'd0;
        tests++;
        if (IF_din !== exp_din) begin
          fails++; $display("FAIL IF_din_idle cyc %0d: got %h expected %h", cyc, IF_din, exp_din);
        end
      end
      if (si < total && !exp_ready) stalls++;
      if (in_valid && exp_ready) begin
        if (first_acc < 0) first_acc = cyc;
        si++;
      end
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; IF_full = 1'b0;
    if (!fin) begin
      tests++; fails++;
      $display("FAIL frame_timeout: got %0d writes expected %0d", wi, total);
    end else begin
      #1;
      tests++;
      if (done !== 1'b1 || busy !== 1'b0 || IF_wen !== 1'b0) begin
        fails++; $display("FAIL frame_end: got done/busy/wen %b/%b/%b expected 1/0/0", done, busy, IF_wen);
      end
      @(negedge clk); #1;
      tests++;
      if (done !== 1'b0) begin
        fails++; $display("FAIL done_width: got %b expected 0", done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; row_len = 8'd0; num_rows = 8'd0;
    in_valid = 1'b1; in_data = 16'hABCD; IF_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({in_ready, IF_wen, busy, done} !== 4'b0000 || IF_din !== 18'd0) begin
      fails++; $display("FAIL reset_outputs: got %b%b%b%b din %h expected 0000 din 0", in_ready, IF_wen, busy, done, IF_din);
    end
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [17:0] gold [6];
    int fa, fw, lw, st;
    gold = '{18'h20001, 18'h00002, 18'h10003, 18'h20004, 18'h00005, 18'h10006};
    src_q.delete();
    for (int i = 1; i <= 6; i++) src_q.push_back(16'(i));
    run_frame(3, 2, 0, 1'b1, -1, fa, fw, lw, st);
    tests++;
    if (wr_log.size() != 6) begin
      fails++; $display("FAIL basic_count: got %0d expected 6", wr_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (wr_log[i] !== gold[i]) begin
          fails++; $display("FAIL basic_word%0d: got %h expected %h", i, wr_log[i], gold[i]);
        end
      end
    end
    tests++;
    if (lw - fw != 5 || fw != fa + 1) begin
      fails++; $display("FAIL basic_timing: got first_acc %0d first_wr %0d last_wr %0d expected 1-cycle latency and 6 consecutive", fa, fw, lw);
    end
  endtask

  task automatic test_row_len_one();
    logic [17:0] gold [3];
    int fa, fw, lw, st;
    gold = '{18'h3FFD7, 18'h30029, 18'h3FFD3};
    src_q.delete();
    src_q.push_back(16'hFFD7); src_q.push_back(16'h0029); src_q.push_back(16'hFFD3);
    run_frame(1, 3, 0, 1'b1, -1, fa, fw, lw, st);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= wr_log.size() || wr_log[i] !== gold[i]) begin
        fails++; $display("FAIL rowlen1_word%0d: got %h expected %h", i, (i < wr_log.size()) ? wr_log[i] : 18'h0, gold[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int fa, fw, lw, st;
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    run_frame(4, 1, -1, 1'b1, -1, fa, fw, lw, st);
    tests++;
    if (st == 0 || wr_log.size() != 4) begin
      fails++; $display("FAIL backpressure: got stalls %0d writes %0d expected stalls>0 writes 4", st, wr_log.size());
    end
  endtask

  task automatic test_zero_config();
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      start = 1'b1;
      row_len = (v == 0) ? 8'd0 : 8'd4;
      num_rows = (v == 0) ? 8'd5 : 8'd0;
      #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++; $display("FAIL zero_cfg%0d_pre: got busy/done %b/%b expected 0/0", v, busy, done);
      end
      @(negedge clk); start = 1'b0; #1;
      tests++;
      if (done !== 1'b1 || busy !== 1'b0 || IF_wen !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL zero_cfg%0d_done: got done/busy/wen/rdy %b/%b/%b/%b expected 1/0/0/0", v, done, busy, IF_wen, in_ready);
      end
      @(negedge clk); #1;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL zero_cfg%0d_after: got done/busy %b/%b expected 0/0", v, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int fa, fw, lw, st;
    @(negedge clk);
    start = 1'b1; row_len = 8'd3; num_rows = 8'd2;
    @(negedge clk);
    start = 1'b0; IF_full = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
    @(negedge clk);
    in_data = 16'h2222;
    @(negedge clk);
    in_valid = 1'b0; IF_full = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    tests++;
    if ({in_ready, IF_wen, busy, done} !== 4'b0000 || IF_din !== 18'd0) begin
      fails++; $display("FAIL midreset_outputs: got %b%b%b%b din %h expected 0000 din 0", in_ready, IF_wen, busy, done, IF_din);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || IF_wen !== 1'b0) begin
        fails++; $display("FAIL midreset_quiet%0d: got done/busy/wen %b/%b/%b expected 0/0/0", i, done, busy, IF_wen);
      end
    end
    src_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(16'($urandom));
    run_frame(3, 2, 0, 1'b1, -1, fa, fw, lw, st);
  endtask

  task automatic test_restart_ignored();
    int fa, fw, lw, st;
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(16'($urandom));
    run_frame(4, 2, 20, 1'b1, 3, fa, fw, lw, st);
  endtask

  task automatic test_random_frames();
    int fa, fw, lw, st, rl, nr;
    for (int f = 0; f < 8; f++) begin
      rl = $urandom_range(1, 5);
      nr = $urandom_range(1, 3);
      src_q.delete();
      for (int i = 0; i < rl * nr; i++) src_q.push_back(16'($urandom));
      run_frame(rl, nr, 40, ($urandom_range(0, 1) == 1), -1, fa, fw, lw, st);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_row_len_one();
    test_backpressure();
    test_zero_config();
    test_reset_mid_frame();
    test_restart_ignored();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
